// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer
// Purpose  : Issues operations to a shared combinational N-bit ALU and owns
//            the architectural flags. Narrow ops take one ALU pass; 2N-bit
//            add/sub (func 4'b00zz with wide set) take two passes, chaining
//            the low-half carry into the high-half pass.
// Ports    : clk, rst_n                   clock, async active-low reset
//            req_*_i / req_ready_o        request handshake (func, wide,
//                                         use_cf, 2N-bit operands)
//            flush_i                      synchronous abort of in-flight op
//            flag_we_i, flag_in_i         direct flag load {c,z,v,n}
//            alu_*_o / alu_*_i            ALU operand drive and result return
//            rsp_valid_o/rsp_ready_i      result handshake, rsp_data_o={hi,lo}
//            flag_{c,z,v,n}_o             architectural flags
// Revision : 1.0 - initial release
// ============================================================================
module alu_sequencer #(
    parameter int N = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req_valid_i,
    output logic           req_ready_o,
    input  logic [3:0]     req_func_i,
    input  logic           req_wide_i,
    input  logic           req_use_cf_i,
    input  logic [2*N-1:0] req_a_i,
    input  logic [2*N-1:0] req_b_i,
    input  logic           flush_i,
    input  logic           flag_we_i,
    input  logic [3:0]     flag_in_i,
    output logic [N-1:0]   alu_a_o,
    output logic [N-1:0]   alu_b_o,
    output logic [3:0]     alu_func_o,
    output logic           alu_ci_o,
    input  logic [N-1:0]   alu_y_i,
    input  logic [N-1:0]   alu_hi_i,
    input  logic           alu_co_i,
    input  logic           alu_zero_i,
    input  logic           alu_ov_i,
    input  logic           alu_neg_i,
    output logic           rsp_valid_o,
    input  logic           rsp_ready_i,
    output logic [2*N-1:0] rsp_data_o,
    output logic           flag_c_o,
    output logic           flag_z_o,
    output logic           flag_v_o,
    output logic           flag_n_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXEC_LO = 2'd1,
        S_EXEC_HI = 2'd2,
        S_RESP    = 2'd3
    } state_e;

    state_e         state_q,    state_d;
    logic [3:0]     func_q,     func_d;
    logic [2*N-1:0] a_q,        a_d;
    logic [2*N-1:0] b_q,        b_d;
    logic           wide_q,     wide_d;
    logic           use_cf_q,   use_cf_d;
    logic           lo_c_q,     lo_c_d;
    logic           lo_z_q,     lo_z_d;
    logic [2*N-1:0] rsp_data_q, rsp_data_d;
    logic [3:0]     flags_q,    flags_d;    // {c,z,v,n}

    logic           w_accept;
    logic           w_req_wide;

    assign req_ready_o = (state_q == S_IDLE) && !flush_i;
    assign w_accept    = req_valid_i && req_ready_o;
    // Only add/sub family (func 00zz) has a two-pass wide form.
    assign w_req_wide  = req_wide_i && (req_func_i[3:2] == 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            func_q     <= '0;
            a_q        <= '0;
            b_q        <= '0;
            wide_q     <= 1'b0;
            use_cf_q   <= 1'b0;
            lo_c_q     <= 1'b0;
            lo_z_q     <= 1'b0;
            rsp_data_q <= '0;
            flags_q    <= '0;
        end else begin
            state_q    <= state_d;
            func_q     <= func_d;
            a_q        <= a_d;
            b_q        <= b_d;
            wide_q     <= wide_d;
            use_cf_q   <= use_cf_d;
            lo_c_q     <= lo_c_d;
            lo_z_q     <= lo_z_d;
            rsp_data_q <= rsp_data_d;
            flags_q    <= flags_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        func_d     = func_q;
        a_d        = a_q;
        b_d        = b_q;
        wide_d     = wide_q;
        use_cf_d   = use_cf_q;
        lo_c_d     = lo_c_q;
        lo_z_d     = lo_z_q;
        rsp_data_d = rsp_data_q;
        // Direct flag load; an ALU capture below overrides it on the same edge.
        flags_d    = flag_we_i ? flag_in_i : flags_q;
        alu_a_o    = '0;
        alu_b_o    = '0;
        alu_func_o = '0;
        alu_ci_o   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    func_d   = req_func_i;
                    a_d      = req_a_i;
                    b_d      = req_b_i;
                    wide_d   = w_req_wide;
                    use_cf_d = req_use_cf_i;
                    state_d  = S_EXEC_LO;
                end
            end

            S_EXEC_LO: begin
                alu_a_o    = a_q[N-1:0];
                alu_b_o    = b_q[N-1:0];
                alu_func_o = func_q;
                alu_ci_o   = use_cf_q && !wide_q && flags_q[3];
                if (flush_i) begin
                    state_d = S_IDLE;
                end else if (wide_q) begin
                    lo_c_d               = alu_co_i;
                    lo_z_d               = alu_zero_i;
                    rsp_data_d[N-1:0]    = alu_y_i;
                    state_d              = S_EXEC_HI;
                end else begin
                    rsp_data_d = {alu_hi_i, alu_y_i};
                    flags_d    = {alu_co_i, alu_zero_i, alu_ov_i, alu_neg_i};
                    state_d    = S_RESP;
                end
            end

            S_EXEC_HI: begin
                alu_a_o    = a_q[2*N-1:N];
                alu_b_o    = b_q[2*N-1:N];
                // Odd code of the pair is the carry/borrow-in variant.
                alu_func_o = func_q | 4'b0001;
                alu_ci_o   = lo_c_q;
                if (flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    rsp_data_d[2*N-1:N] = alu_y_i;
                    // Wide result is zero only if both halves were zero.
                    flags_d = {alu_co_i, lo_z_q & alu_zero_i, alu_ov_i, alu_neg_i};
                    state_d = S_RESP;
                end
            end

            S_RESP: begin
                if (flush_i || rsp_ready_i) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign rsp_valid_o = (state_q == S_RESP);
    assign rsp_data_o  = rsp_data_q;
    assign flag_c_o    = flags_q[3];
    assign flag_z_o    = flags_q[2];
    assign flag_v_o    = flags_q[1];
    assign flag_n_o    = flags_q[0];

endmodule
`default_nettype wire
